// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data-memory port-B arbiter: default widths,
// requester IDs and the read-pipeline entry type.
package mem_arb_pkg;

   localparam int unsigned ADDR_W_DEF = 16;
   localparam int unsigned DATA_W_DEF = 16;

   localparam logic REQ_VGA = 1'b0;
   localparam logic REQ_IO  = 1'b1;

   typedef struct packed {
      logic valid;
      logic owner;
   } rd_entry_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating wait counter used to bound how long requester 1 can be held off.
module arb_starve_counter #(
   parameter int unsigned MaxCount = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic inc_i,
   input  logic clr_i,
   output logic at_max_o
);

   localparam int unsigned CntW = $clog2(MaxCount + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(MaxCount);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != CntMax)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_max_o = (cnt_q >= CntMax);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for block-RAM port B: fixed priority to the display
// reader, with a starvation bound for the I/O requester and a 2-stage read tag pipe.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned WAIT_MAX = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              grant0,
   output logic              rvalid0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              grant1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_q
);

   logic              at_max;
   logic              starved;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_din_q, mem_din_d;
   logic              mem_we_q, mem_we_d;
   rd_entry_t         stage1_q, stage1_d;
   rd_entry_t         stage2_q, stage2_d;

   arb_starve_counter #(
      .MaxCount (WAIT_MAX)
   ) u_starve (
      .clk_i    (clk),
      .rst_i    (reset),
      .inc_i    (req1 && !grant1),
      .clr_i    (!req1 || grant1),
      .at_max_o (at_max)
   );

   assign starved = at_max && req1;

   always_comb begin
      grant1 = !reset && req1 && (!req0 || starved);
      grant0 = !reset && req0 && !grant1;
   end

   // Address/data hold when idle; only the write enable drops.
   always_comb begin
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      mem_we_d   = 1'b0;
      stage1_d   = '0;
      stage2_d   = stage1_q;
      if (grant1) begin
         mem_addr_d = addr1;
         mem_din_d  = wdata1;
         mem_we_d   = we1;
         stage1_d   = '{valid: !we1, owner: REQ_IO};
      end else if (grant0) begin
         mem_addr_d = addr0;
         mem_din_d  = wdata0;
         mem_we_d   = we0;
         stage1_d   = '{valid: !we0, owner: REQ_VGA};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         mem_we_q   <= 1'b0;
         stage1_q   <= '0;
         stage2_q   <= '0;
      end else begin
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         mem_we_q   <= mem_we_d;
         stage1_q   <= stage1_d;
         stage2_q   <= stage2_d;
      end
   end

   assign mem_addr = mem_addr_q;
   assign mem_din  = mem_din_q;
   assign mem_we   = mem_we_q;
   assign rdata    = mem_q;
   assign rvalid0  = stage2_q.valid && (stage2_q.owner == REQ_VGA);
   assign rvalid1  = stage2_q.valid && (stage2_q.owner == REQ_IO);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-memory port B between two requesters: requester 0 (display/VGA frame reader) and requester 1 (I/O and peripheral writer, e.g. SNES state store).
- At most one memory access is issued per cycle.
- Requester 0 has fixed priority. A starvation counter guarantees requester 1 a grant within WAIT_MAX cycles.
- Sits between the requesters and the block-RAM port B, which the CPU FSM does not drive.

Parameters:
ADDR_W, 16, memory word address width
DATA_W, 16, memory data width
WAIT_MAX, 8, cycles requester 1 may wait before it overrides requester 0 (1..255)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req0  in  1  requester 0 access request; held with addr0/we0/wdata0 until accepted
we0  in  1  requester 0 write (1) / read (0)
addr0  in  ADDR_W  requester 0 address
wdata0  in  DATA_W  requester 0 write data
grant0  out  1  combinational; transfer for requester 0 occurs at the rising edge where req0 && grant0
rvalid0  out  1  requester 0 read data valid (one-cycle pulse)
req1, we1, addr1, wdata1, grant1, rvalid1  as above, for requester 1
rdata  out  DATA_W  read data; direct pass-through of mem_q, shared by both requesters
mem_addr  out  ADDR_W  registered port-B address
mem_din  out  DATA_W  registered port-B write data
mem_we  out  1  registered port-B write enable
mem_q  in  DATA_W  port-B read data; RAM registers the address, so data is valid the cycle after mem_addr is presented

Behaviour:
- Reset values:
  - mem_addr=0, mem_din=0, mem_we=0.
  - rvalid0=rvalid1=0.
  - Starvation count=0.
  - Read pipeline flags cleared.
  - grant0/grant1 are 0 while reset=1.
- Arbitration (combinational on current inputs and the starvation count):
  - starved = (count >= WAIT_MAX) && req1.
  - grant1 = req1 && (!req0 || starved).
  - grant0 = req0 && !grant1.
  - At most one grant is high in any cycle.
- Transfer at edge N, winner i:
  - mem_addr<=addr_i, mem_din<=wdata_i, mem_we<=we_i.
- No transfer at edge N:
  - mem_we<=0.
  - mem_addr and mem_din hold their values.
- Read latency:
  - A read transfer at edge N sets stage1 {valid, owner=i}.
  - At edge N+1, stage1 moves to stage2, which drives rvalid_i.
  - rvalid_i is therefore high exactly during the cycle after edge N+1, aligned with mem_q for that address.
  - Writes never produce rvalid.
- Throughput:
  - Back-to-back transfers are allowed, including repeated transfers by the same requester.
  - rvalid pulses return in issue order, one per read, at one-cycle spacing.
- Starvation counter (saturating at WAIT_MAX):
  - Increments each edge with req1 && !grant1.
  - Clears at an edge where req1 && grant1, or where req1=0.
- Requester rules:
  - A requester may drop req before it is granted; nothing is issued.
  - A requester must change its fields or drop req in the cycle its grant is high if it wants no further access. Otherwise the same access repeats at the next edge.
- Simultaneous events:
  - A write by requester 0 followed by a read of the same address at the next edge returns the new data, because the RAM is read-after-write on the port.
  - Any combination of req0 and req1 resolves by the rules above.
- Reset mid-operation:
  - Pending stage1/stage2 entries are discarded, so no rvalid appears after reset.
  - mem_we is forced to 0 at the reset edge.
  - Requesters must re-issue any lost reads.

Decomposition:
- Shared package mem_arb_pkg: ADDR_W/DATA_W defaults, the requester ID constants REQ_VGA=0 and REQ_IO=1, and the read-pipeline entry typedef {valid, owner}.
- One sub-module: arb_starve_counter (parameterised saturating counter with inc/clr inputs and an at_max output).
- Grant logic, port registers and the read pipeline stay in the top module.

Test Plan:
- Reset: hold reset 3 cycles with req0=req1=1 -> grants 0, mem_we=0, mem_addr=0, no rvalid; after release grant0=1 in the first cycle.
- Single read: req1=1, we1=0, addr1=0x0123, with RAM[0x0123]=0x5A5A -> grant1 in the same cycle; mem_addr=0x0123 after edge N; rvalid1=1 with rdata=0x5A5A during the cycle after edge N+1, for exactly one cycle.
- Write: req0=1, we0=1, addr0=0x0200, wdata0=0xBEEF for one transfer -> mem_we high one cycle with mem_din=0xBEEF; no rvalid0; a subsequent read of 0x0200 returns 0xBEEF.
- Starvation with WAIT_MAX=4 and req0, req1 held high for 10 transfers -> grant sequence 0,0,0,0,1,0,0,0,0,1.
- Pipelined reads: req0 reads 0x0010, 0x0011, 0x0012 on consecutive edges -> rvalid0 high three consecutive cycles with rdata equal to the three RAM words in order; rvalid1 stays 0.
- Reset mid-read: assert reset one cycle after a read transfer -> no rvalid at any time; starvation count=0 after release.
